// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: FSM state encoding,
// default watchdog limit and completed-op counter width.
package fpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  localparam int unsigned WDOG_MAX_DEFAULT = 255;
  localparam int unsigned OPCNT_W          = 16;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one FP op from execute, launches it on the
// FPU, waits for the result and hands it to writeback. Tracks the pending
// destination for decode hazard checks, aborts hung ops via a watchdog and
// counts completed ops.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   reqValid_i/reqReady_o     issue handshake; reqInstr_i, reqRs1_i..reqRs3_i,
//                             reqRd_i, reqRdIsF_i carry the op
//   flush_i                   cancels the in-flight op
//   fpuEnable_o, fpuInstr_o,  one-cycle launch pulse and held operands
//   fpuRs1_o..fpuRs3_o
//   fpuBusy_i, fpuOut_i       FPU status and result
//   wbValid_o/wbReady_i,      writeback handshake and payload
//   wbData_o, wbRd_o, wbRdIsF_o
//   stall_o, pendValid_o,     hazard info for decode
//   pendRd_o, pendRdIsF_o
//   wdogErr_o                 sticky watchdog abort flag
//   opCount_o                 completed-op counter (wraps)
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               reqValid_i,
  output logic               reqReady_o,
  input  logic [31:0]        reqInstr_i,
  input  logic [31:0]        reqRs1_i,
  input  logic [31:0]        reqRs2_i,
  input  logic [31:0]        reqRs3_i,
  input  logic [4:0]         reqRd_i,
  input  logic               reqRdIsF_i,
  input  logic               flush_i,
  output logic               fpuEnable_o,
  output logic [31:0]        fpuInstr_o,
  output logic [31:0]        fpuRs1_o,
  output logic [31:0]        fpuRs2_o,
  output logic [31:0]        fpuRs3_o,
  input  logic               fpuBusy_i,
  input  logic [31:0]        fpuOut_i,
  output logic               wbValid_o,
  input  logic               wbReady_i,
  output logic [31:0]        wbData_o,
  output logic [4:0]         wbRd_o,
  output logic               wbRdIsF_o,
  output logic               stall_o,
  output logic [4:0]         pendRd_o,
  output logic               pendRdIsF_o,
  output logic               pendValid_o,
  output logic               wdogErr_o,
  output logic [OPCNT_W-1:0] opCount_o
);

  state_e               r_state;
  state_e               w_stateNext;
  logic [31:0]          r_instr, r_rs1, r_rs2, r_rs3, r_wbData;
  logic [4:0]           r_rd;
  logic                 r_rdIsF;
  logic [31:0]          r_wdog;
  logic                 r_wdogErr;
  logic [OPCNT_W-1:0]   r_opCount;

  logic w_accept, w_wdogHit, w_resultNow, w_wbFire;
  logic w_wdogInc, w_wdogErrSet, w_capture;

  assign reqReady_o  = (r_state == S_IDLE) && !flush_i;
  assign w_accept    = reqValid_i && reqReady_o;
  assign w_wdogHit   = (r_wdog + 32'd1) >= WDOG_MAX;

  always_comb begin
    w_stateNext  = r_state;
    w_wdogInc    = 1'b0;
    w_wdogErrSet = 1'b0;
    w_capture    = 1'b0;
    w_resultNow  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_stateNext = S_LAUNCH;
      S_LAUNCH: w_stateNext = flush_i ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (fpuBusy_i) begin
          w_wdogInc = 1'b1;
          if (w_wdogHit) begin
            w_wdogErrSet = 1'b1;
            w_stateNext  = S_IDLE;
          end else if (flush_i) begin
            w_stateNext = S_DRAIN;
          end
        end else if (flush_i) begin
          w_stateNext = S_DRAIN;
        end else begin
          // Result is offered on the writeback port in the cycle busy drops;
          // WB only holds the captured copy while the consumer stalls.
          w_resultNow = 1'b1;
          w_capture   = 1'b1;
          w_stateNext = wbReady_i ? S_IDLE : S_WB;
        end
      end
      S_WB:     if (flush_i || wbReady_i) w_stateNext = S_IDLE;
      S_DRAIN: begin
        if (fpuBusy_i) begin
          w_wdogInc = 1'b1;
          if (w_wdogHit) begin
            w_wdogErrSet = 1'b1;
            w_stateNext  = S_IDLE;
          end
        end else begin
          w_stateNext = S_IDLE;
        end
      end
      default:  w_stateNext = S_IDLE;
    endcase
  end

  assign fpuEnable_o = (r_state == S_LAUNCH) && !flush_i;
  assign fpuInstr_o  = r_instr;
  assign fpuRs1_o    = r_rs1;
  assign fpuRs2_o    = r_rs2;
  assign fpuRs3_o    = r_rs3;

  assign wbValid_o   = (r_state == S_WB) || w_resultNow;
  assign wbData_o    = w_resultNow ? fpuOut_i : r_wbData;
  assign wbRd_o      = r_rd;
  assign wbRdIsF_o   = r_rdIsF;
  // A flush in WB cancels the op even if the consumer accepts this cycle.
  assign w_wbFire    = wbValid_o && wbReady_i && !flush_i;

  assign stall_o     = (r_state != S_IDLE) || w_accept;
  assign pendValid_o = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_WB);
  assign pendRd_o    = r_rd;
  assign pendRdIsF_o = r_rdIsF;
  assign wdogErr_o   = r_wdogErr;
  assign opCount_o   = r_opCount;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rs3     <= '0;
      r_rd      <= '0;
      r_rdIsF   <= 1'b0;
      r_wbData  <= '0;
      r_wdog    <= '0;
      r_wdogErr <= 1'b0;
      r_opCount <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_instr <= reqInstr_i;
        r_rs1   <= reqRs1_i;
        r_rs2   <= reqRs2_i;
        r_rs3   <= reqRs3_i;
        r_rd    <= reqRd_i;
        r_rdIsF <= reqRdIsF_i;
        r_wdog  <= '0;
      end else if (w_wdogInc) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if (w_capture)    r_wbData  <= fpuOut_i;
      if (w_wdogErrSet) r_wdogErr <= 1'b1;
      if (w_wbFire)     r_opCount <= r_opCount + OPCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i, reqValid_i, reqRdIsF_i, flush_i, fpuBusy_i, wbReady_i;
  logic [31:0] reqInstr_i, reqRs1_i, reqRs2_i, reqRs3_i, fpuOut_i;
  logic [4:0]  reqRd_i;
  logic        reqReady_o, fpuEnable_o, wbValid_o, wbRdIsF_o, stall_o;
  logic        pendRdIsF_o, pendValid_o, wdogErr_o;
  logic [31:0] fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o, wbData_o;
  logic [4:0]  wbRd_o, pendRd_o;
  logic [15:0] opCount_o;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  fpu_issue_ctrl #(.WDOG_MAX(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .reqValid_i(reqValid_i), .reqReady_o(reqReady_o),
    .reqInstr_i(reqInstr_i), .reqRs1_i(reqRs1_i), .reqRs2_i(reqRs2_i), .reqRs3_i(reqRs3_i),
    .reqRd_i(reqRd_i), .reqRdIsF_i(reqRdIsF_i), .flush_i(flush_i),
    .fpuEnable_o(fpuEnable_o), .fpuInstr_o(fpuInstr_o),
    .fpuRs1_o(fpuRs1_o), .fpuRs2_o(fpuRs2_o), .fpuRs3_o(fpuRs3_o),
    .fpuBusy_i(fpuBusy_i), .fpuOut_i(fpuOut_i),
    .wbValid_o(wbValid_o), .wbReady_i(wbReady_i), .wbData_o(wbData_o),
    .wbRd_o(wbRd_o), .wbRdIsF_o(wbRdIsF_o),
    .stall_o(stall_o), .pendRd_o(pendRd_o), .pendRdIsF_o(pendRdIsF_o),
    .pendValid_o(pendValid_o), .wdogErr_o(wdogErr_o), .opCount_o(opCount_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_accept(input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] rs3,
                           input logic [4:0] rd, input logic isf);
    reqInstr_i = instr; reqRs1_i = rs1; reqRs2_i = rs2; reqRs3_i = rs3;
    reqRd_i = rd; reqRdIsF_i = isf; reqValid_i = 1'b1;
    #1;
    chkb("acc_ready", reqReady_o, 1'b1);
    chkb("acc_stall", stall_o, 1'b1);
    tick();
    reqValid_i = 1'b0;
    reqInstr_i = '1; reqRs1_i = '1; reqRs2_i = '1; reqRs3_i = '1; reqRd_i = '1;
  endtask

  initial begin
    reset_i = 1'b1; reqValid_i = 1'b0; reqRdIsF_i = 1'b0; flush_i = 1'b0;
    fpuBusy_i = 1'b0; wbReady_i = 1'b0; reqInstr_i = '0; reqRs1_i = '0;
    reqRs2_i = '0; reqRs3_i = '0; fpuOut_i = '0; reqRd_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    #1;
    chkb("rst_ready", reqReady_o, 1'b1);
    chkb("rst_wbv", wbValid_o, 1'b0);
    chkb("rst_en", fpuEnable_o, 1'b0);
    chkb("rst_stall", stall_o, 1'b0);
    chkb("rst_pend", pendValid_o, 1'b0);
    chkb("rst_wdog", wdogErr_o, 1'b0);
    chk("rst_cnt", 32'(opCount_o), 32'd0);
    chk("rst_wbdata", wbData_o, 32'd0);
    chk("rst_instr", fpuInstr_o, 32'd0);

    // fsgnj.s, result ready straight after launch
    do_accept(32'h20B50553, 32'hBF800000, 32'h0, 32'h0, 5'd10, 1'b1);
    fpuBusy_i = 1'b1; wbReady_i = 1'b1; #1;
    chkb("t1_en", fpuEnable_o, 1'b1);
    chk("t1_instr", fpuInstr_o, 32'h20B50553);
    chk("t1_rs1", fpuRs1_o, 32'hBF800000);
    chk("t1_rs2", fpuRs2_o, 32'h0);
    chkb("t1_pend", pendValid_o, 1'b1);
    chk("t1_pendrd", 32'(pendRd_o), 32'd10);
    chkb("t1_wbv0", wbValid_o, 1'b0);
    tick();
    fpuBusy_i = 1'b0; fpuOut_i = 32'h3F800000; #1;
    chkb("t1_wbv", wbValid_o, 1'b1);
    chk("t1_wbdata", wbData_o, 32'h3F800000);
    chk("t1_wbrd", 32'(wbRd_o), 32'd10);
    chkb("t1_wbisf", wbRdIsF_o, 1'b1);
    chkb("t1_en0", fpuEnable_o, 1'b0);
    chk("t1_instr_hold", fpuInstr_o, 32'h20B50553);
    tick();
    fpuOut_i = '0; wbReady_i = 1'b0; #1;
    chk("t1_cnt", 32'(opCount_o), 32'd1);
    chkb("t1_ready", reqReady_o, 1'b1);
    chkb("t1_wbv_end", wbValid_o, 1'b0);
    chkb("t1_stall_end", stall_o, 1'b0);

    // fadd.s, busy 4 cycles, then consumer stalls 3 cycles
    do_accept(32'h00B50553, 32'h3F800000, 32'h40000000, 32'h0, 5'd7, 1'b1);
    fpuBusy_i = 1'b0; #1;
    chkb("t2_en", fpuEnable_o, 1'b1);
    chk("t2_pendrd", 32'(pendRd_o), 32'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      fpuBusy_i = 1'b1; #1;
      chkb("t2_wait_wbv", wbValid_o, 1'b0);
      chkb("t2_wait_pend", pendValid_o, 1'b1);
      chk("t2_wait_pendrd", 32'(pendRd_o), 32'd7);
      tick();
    end
    fpuBusy_i = 1'b0; fpuOut_i = 32'h40400000; wbReady_i = 1'b0; #1;
    chkb("t2_wbv", wbValid_o, 1'b1);
    chk("t2_wbdata", wbData_o, 32'h40400000);
    tick();
    for (int i = 0; i < 2; i++) begin
      fpuOut_i = 32'hDEADBEEF; fpuBusy_i = 1'b1; #1;
      chkb("t2_hold_wbv", wbValid_o, 1'b1);
      chk("t2_hold_data", wbData_o, 32'h40400000);
      chkb("t2_hold_ready", reqReady_o, 1'b0);
      chkb("t2_hold_stall", stall_o, 1'b1);
      chkb("t2_hold_pend", pendValid_o, 1'b1);
      tick();
    end
    wbReady_i = 1'b1; #1;
    chkb("t2_fire_wbv", wbValid_o, 1'b1);
    chk("t2_fire_data", wbData_o, 32'h40400000);
    chk("t2_fire_cnt", 32'(opCount_o), 32'd1);
    tick();
    wbReady_i = 1'b0; fpuBusy_i = 1'b0; #1;
    chkb("t2_ready", reqReady_o, 1'b1);
    chk("t2_cnt", 32'(opCount_o), 32'd2);

    // flush during WAIT, FPU drains
    do_accept(32'h08B50553, 32'h1, 32'h2, 32'h3, 5'd3, 1'b1);
    #1;
    chkb("t3_en", fpuEnable_o, 1'b1);
    tick();
    fpuBusy_i = 1'b1; flush_i = 1'b1; #1;
    chkb("t3_flush_wbv", wbValid_o, 1'b0);
    chkb("t3_flush_ready", reqReady_o, 1'b0);
    tick();
    flush_i = 1'b0; #1;
    chkb("t3_drain_pend", pendValid_o, 1'b0);
    chkb("t3_drain_stall", stall_o, 1'b1);
    chkb("t3_drain_wbv", wbValid_o, 1'b0);
    tick();
    #1;
    chkb("t3_drain_ready", reqReady_o, 1'b0);
    tick();
    fpuBusy_i = 1'b0; fpuOut_i = 32'h12345678; #1;
    chkb("t3_done_wbv", wbValid_o, 1'b0);
    chkb("t3_done_ready", reqReady_o, 1'b0);
    tick();
    #1;
    chkb("t3_ready", reqReady_o, 1'b1);
    chk("t3_cnt", 32'(opCount_o), 32'd2);
    chkb("t3_wbv", wbValid_o, 1'b0);

    // flush during LAUNCH
    do_accept(32'h10B50553, 32'h4, 32'h5, 32'h6, 5'd4, 1'b0);
    flush_i = 1'b1; #1;
    chkb("t4_en", fpuEnable_o, 1'b0);
    chkb("t4_ready", reqReady_o, 1'b0);
    tick();
    flush_i = 1'b0; #1;
    chkb("t4_idle_ready", reqReady_o, 1'b1);
    chkb("t4_idle_pend", pendValid_o, 1'b0);

    // flush beats a request in IDLE
    reqValid_i = 1'b1; flush_i = 1'b1; #1;
    chkb("t5_ready", reqReady_o, 1'b0);
    chkb("t5_stall", stall_o, 1'b0);
    tick();
    reqValid_i = 1'b0; flush_i = 1'b0; #1;
    chkb("t5_idle_ready", reqReady_o, 1'b1);
    chkb("t5_idle_pend", pendValid_o, 1'b0);
    chk("t5_cnt", 32'(opCount_o), 32'd2);

    // flush in WB with the consumer ready in the same cycle
    do_accept(32'h18B50553, 32'h7, 32'h8, 32'h9, 5'd9, 1'b0);
    tick();
    fpuBusy_i = 1'b0; fpuOut_i = 32'hCAFEF00D; wbReady_i = 1'b0; #1;
    chkb("t6_wbv", wbValid_o, 1'b1);
    chkb("t6_wbisf", wbRdIsF_o, 1'b0);
    tick();
    flush_i = 1'b1; wbReady_i = 1'b1; #1;
    chkb("t6_flush_wbv", wbValid_o, 1'b1);
    chk("t6_flush_data", wbData_o, 32'hCAFEF00D);
    tick();
    flush_i = 1'b0; wbReady_i = 1'b0; #1;
    chkb("t6_after_wbv", wbValid_o, 1'b0);
    chk("t6_cnt", 32'(opCount_o), 32'd2);
    chkb("t6_ready", reqReady_o, 1'b1);

    // watchdog: busy stuck high for 8 WAIT cycles
    do_accept(32'h00C58553, 32'hA, 32'hB, 32'hC, 5'd12, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      fpuBusy_i = 1'b1; #1;
      chkb("t7_wait_err", wdogErr_o, 1'b0);
      chkb("t7_wait_wbv", wbValid_o, 1'b0);
      tick();
    end
    #1;
    chkb("t7_err", wdogErr_o, 1'b1);
    chkb("t7_ready", reqReady_o, 1'b1);
    chkb("t7_pend", pendValid_o, 1'b0);
    chkb("t7_wbv", wbValid_o, 1'b0);
    chk("t7_cnt", 32'(opCount_o), 32'd2);
    // next op: 7 busy cycles must not trip the freshly cleared watchdog
    do_accept(32'h00D60553, 32'hD, 32'hE, 32'hF, 5'd13, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      fpuBusy_i = 1'b1; #1;
      chkb("t7b_wait_wbv", wbValid_o, 1'b0);
      tick();
    end
    fpuBusy_i = 1'b0; fpuOut_i = 32'h0BADCAFE; wbReady_i = 1'b1; #1;
    chkb("t7b_wbv", wbValid_o, 1'b1);
    chk("t7b_data", wbData_o, 32'h0BADCAFE);
    tick();
    wbReady_i = 1'b0; #1;
    chk("t7b_cnt", 32'(opCount_o), 32'd3);
    chkb("t7b_err_sticky", wdogErr_o, 1'b1);

    // reset while holding a result in WB
    do_accept(32'h20E70553, 32'h11, 32'h22, 32'h33, 5'd14, 1'b1);
    tick();
    fpuBusy_i = 1'b0; fpuOut_i = 32'h55AA55AA; wbReady_i = 1'b0; #1;
    tick();
    reset_i = 1'b1; #1;
    chkb("t8_wb_before", wbValid_o, 1'b1);
    tick();
    reset_i = 1'b0; #1;
    chkb("t8_wbv", wbValid_o, 1'b0);
    chk("t8_cnt", 32'(opCount_o), 32'd0);
    chkb("t8_ready", reqReady_o, 1'b1);
    chkb("t8_err", wdogErr_o, 1'b0);
    chk("t8_wbdata", wbData_o, 32'd0);
    chk("t8_instr", fpuInstr_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
